// File: rtl/midi_encoder.sv
// midi_encoder: queues note/param events and serialises them as 3-byte MIDI messages over a byte handshake.
// Optional running status (status reuse, note-off as note-on vel 0, idle expiry) under MIDI_RUNNING_STATUS_EN.
module midi_encoder #(
    parameter logic [3:0] CHANNEL        = 4'd0,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         RS_IDLE_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       event_valid,
    output logic       event_ready,
    input  logic [1:0] event_kind,
    input  logic [6:0] note,
    input  logic [6:0] velocity,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] MIDIbyte,
    output logic       busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_DATA1, SEND_DATA2} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    st_q, st_d, d1_q, d1_d, d2_q, d2_d;
    logic          push, pop, empty, full, skip;
    logic [15:0]   head;
    logic [1:0]    hkind;
    logic [7:0]    hstatus, hd2;

    assign empty       = cnt_q == '0;
    assign full        = cnt_q == CW'(FIFO_DEPTH);
    assign event_ready = !full;
    assign push        = event_valid && !full;
    assign pop         = state_q == IDLE && !empty;
    assign head        = mem_q[rd_q];
    assign hkind       = head[15:14];
    assign byte_valid  = state_q != IDLE;
    assign busy        = !empty || byte_valid;
    assign MIDIbyte    = state_q == SEND_STATUS ? st_q :
                         state_q == SEND_DATA1  ? d1_q :
                         state_q == SEND_DATA2  ? d2_q : 8'h00;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0]  last_q, last_d;
    logic [31:0] idle_q, idle_d;

    // Note-off travels as note-on with velocity 0 so it can share running status.
    assign hstatus = {hkind[1] ? 4'hB : 4'h9, CHANNEL};
    assign hd2     = hkind == 2'b00 ? 8'h00 : {1'b0, head[6:0]};
    assign skip    = hstatus == last_q;

    always_comb begin
        last_d = last_q;
        idle_d = idle_q;
        if (state_q == SEND_STATUS && byte_ready)
            last_d = st_q;
        if (pop)
            idle_d = '0;
        else if (state_q == IDLE && empty) begin
            if (idle_q >= 32'(RS_IDLE_CYCLES - 1))
                last_d = 8'h00;
            else
                idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 8'h00;
            idle_q <= '0;
        end else begin
            last_q <= last_d;
            idle_q <= idle_d;
        end
    end
`else
    logic unused_rs;

    assign unused_rs = RS_IDLE_CYCLES[0];
    assign hstatus   = {hkind[1] ? 4'hB : hkind[0] ? 4'h9 : 4'h8, CHANNEL};
    assign hd2       = {1'b0, head[6:0]};
    assign skip      = 1'b0;
`endif

    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        st_d    = st_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        if (push)
            mem_d[wr_q] = {event_kind, note, velocity};
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        unique case (state_q)
            IDLE: begin
                // Reserved kinds are popped without touching the holding register.
                if (pop && hkind != 2'b11) begin
                    st_d    = hstatus;
                    d1_d    = {1'b0, head[13:7]};
                    d2_d    = hd2;
                    state_d = skip ? SEND_DATA1 : SEND_STATUS;
                end
            end
            SEND_STATUS: if (byte_ready) state_d = SEND_DATA1;
            SEND_DATA1:  if (byte_ready) state_d = SEND_DATA2;
            SEND_DATA2:  if (byte_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            st_q    <= 8'h00;
            d1_q    <= 8'h00;
            d2_q    <= 8'h00;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end
endmodule

// File: tb/tb_midi_encoder.sv
// tb_midi_encoder: directed events with an expected-byte queue checked by an independent output monitor.
module tb_midi_encoder;
    localparam logic [3:0] CH = 4'd3;
    localparam int         RS = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       event_valid = 1'b0;
    logic       event_ready;
    logic [1:0] event_kind = 2'b00;
    logic [6:0] note = 7'd0;
    logic [6:0] velocity = 7'd0;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic [7:0] MIDIbyte;
    logic       busy;

    logic [7:0] exp_q[$];
    logic [7:0] tb_last = 8'h00;
    int         tests = 0;
    int         fails = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    midi_encoder #(.CHANNEL(CH), .FIFO_DEPTH(4), .RS_IDLE_CYCLES(RS)) dut (
        .clk(clk), .reset(reset), .event_valid(event_valid), .event_ready(event_ready),
        .event_kind(event_kind), .note(note), .velocity(velocity), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .MIDIbyte(MIDIbyte), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset)
            prev_hold = 1'b0;
        else begin
            if (prev_hold) begin
                check("hold_valid", 32'(byte_valid), 32'd1);
                check("hold_byte", 32'(MIDIbyte), 32'(prev_byte));
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none", MIDIbyte);
                end else
                    check("byte", 32'(MIDIbyte), 32'(exp_q.pop_front()));
            end
            prev_hold = byte_valid && !byte_ready;
            prev_byte = MIDIbyte;
        end
    end

    task automatic expect_msg(input logic [1:0] k, input logic [6:0] n, input logic [6:0] v);
        logic [7:0] s;
        if (k == 2'b11) return;
`ifdef MIDI_RUNNING_STATUS_EN
        s = {k[1] ? 4'hB : 4'h9, CH};
        if (s != tb_last) exp_q.push_back(s);
        tb_last = s;
        exp_q.push_back({1'b0, n});
        exp_q.push_back(k == 2'b00 ? 8'h00 : {1'b0, v});
`else
        s = {k == 2'b10 ? 4'hB : k == 2'b01 ? 4'h9 : 4'h8, CH};
        exp_q.push_back(s);
        exp_q.push_back({1'b0, n});
        exp_q.push_back({1'b0, v});
`endif
    endtask

    task automatic send(input logic [1:0] k, input logic [6:0] n, input logic [6:0] v);
        logic got = 1'b0;
        event_valid = 1'b1;
        event_kind  = k;
        note        = n;
        velocity    = v;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (event_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (got) expect_msg(k, n, v);
        else check("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1 event_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        tb_last = 8'h00;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_byte", 32'(MIDIbyte), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(event_ready), 32'd1);
        @(posedge clk);
        #1;

        // Test 1: latency and basic NOTE_ON encoding
        byte_ready = 1'b1;
        send(2'b01, 7'd60, 7'd100);
        @(negedge clk);
        check("lat_n1_valid", 32'(byte_valid), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(byte_valid), 32'd1);
        check("lat_status", 32'(MIDIbyte), 32'h93);
        drain();

        // Test 2: stall mid-message
        byte_ready = 1'b0;
        send(2'b01, 7'd64, 7'd80);
        repeat (3) @(posedge clk);
        #1 byte_ready = 1'b1;
        @(posedge clk);
        #1 byte_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 byte_ready = 1'b1;
        drain();

        // Test 3: fill the FIFO with the sink blocked, then release
        byte_ready = 1'b0;
        send(2'b01, 7'd60, 7'd100);
        send(2'b00, 7'd60, 7'd64);
        send(2'b10, 7'd7, 7'd127);
        send(2'b01, 7'd62, 7'd90);
        send(2'b00, 7'd62, 7'd0);
        event_valid = 1'b1;
        event_kind  = 2'b01;
        note        = 7'd1;
        velocity    = 7'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_ready", 32'(event_ready), 32'd0);
            check("full_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 event_valid = 1'b0;
        byte_ready = 1'b1;
        drain();

        // Test 4: param change and a dropped reserved event
        send(2'b10, 7'd7, 7'd127);
        send(2'b01, 7'd48, 7'd1);
        send(2'b11, 7'd5, 7'd5);
        send(2'b01, 7'd50, 7'd2);
        drain();

        // Test 5: reset while data1 is on the bus
        do_reset();
        byte_ready = 1'b0;
        send(2'b01, 7'd70, 7'd33);
        repeat (2) @(posedge clk);
        #1 byte_ready = 1'b1;
        @(posedge clk);
        #1 byte_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(byte_valid), 32'd1);
        check("pre_rst_byte", 32'(MIDIbyte), 32'h46);
        reset = 1'b1;
        exp_q.delete();
        tb_last = 8'h00;
        #1;
        check("async_rst_valid", 32'(byte_valid), 32'd0);
        check("async_rst_byte", 32'(MIDIbyte), 32'h00);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        byte_ready = 1'b1;
        send(2'b01, 7'd71, 7'd34);
        drain();

`ifdef MIDI_RUNNING_STATUS_EN
        // Test 6: running status, note-off as vel 0, idle expiry
        do_reset();
        byte_ready = 1'b1;
        send(2'b01, 7'd60, 7'd100);
        send(2'b00, 7'd60, 7'd64);
        send(2'b01, 7'd62, 7'd90);
        drain();
        repeat (RS + 8) @(posedge clk);
        #1 tb_last = 8'h00;
        send(2'b01, 7'd60, 7'd100);
        drain();
`endif

        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
